ex_flush_ctrl: RTL and testbench

//  Sequences the pipeline flush and fetch redirect on an exception or ERET from the WB stage.

---
 rtl/ex_flush_ctrl_pkg.sv | 13 +
 rtl/inst_inflight_cnt.sv | 30 +++
 rtl/ex_flush_ctrl.sv | 100 ++++++++++
 tb/tb_ex_flush_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_flush_ctrl_pkg.sv
// Shared types and constants for the exception/ERET flush controller.
package ex_flush_ctrl_pkg;

    localparam logic [31:0] EX_VECTOR_PC = 32'hbfc00380;

    // 2'd3 is unused; the FSM falls back to FC_IDLE if it is ever seen.
    typedef enum logic [1:0] {
        FC_IDLE  = 2'd0,
        FC_DRAIN = 2'd1,
        FC_REDIR = 2'd2
    } fc_state_e;

endpackage

// File: rtl/inst_inflight_cnt.sv
// Up/down saturating count of inst-SRAM requests accepted but not yet answered.
module inst_inflight_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nxt
);

    always_comb begin
        cnt_nxt = cnt;
        if (inc && !dec && cnt != '1) begin
            cnt_nxt = cnt + 1'b1;
        end else if (!inc && dec && cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/ex_flush_ctrl.sv
// Flushes the pipeline on a WB exception/ERET, drains stale inst responses,
// then holds the fetch redirect until pre-IF takes it.
module ex_flush_ctrl
    import ex_flush_ctrl_pkg::*;
#(
    parameter logic [31:0] EX_VECTOR = EX_VECTOR_PC,
    parameter int          CNT_W     = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ws_ex_i,
    input  logic             ws_eret_i,
    input  logic [31:0]      cp0_epc_i,
    input  logic             inst_req_i,
    input  logic             inst_addr_ok_i,
    input  logic             inst_data_ok_i,
    input  logic             redirect_ready_i,
    output logic             flush_o,
    output logic             fetch_hold_o,
    output logic             inst_discard_o,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    output logic [CNT_W-1:0] outstanding_o
);

    fc_state_e        state_q;
    fc_state_e        state_d;
    logic [31:0]      target_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ev;
    logic             capture;

    assign ev = ws_ex_i | ws_eret_i;

    inst_inflight_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (inst_req_i & inst_addr_ok_i),
        .dec    (inst_data_ok_i),
        .cnt    (outstanding_o),
        .cnt_nxt(cnt_nxt)
    );

    // A request accepted in the event cycle is already in cnt_nxt,
    // so its response is drained rather than leaking into IF.
    always_comb begin
        state_d          = state_q;
        capture          = 1'b0;
        flush_o          = 1'b0;
        fetch_hold_o     = 1'b0;
        inst_discard_o   = 1'b0;
        redirect_valid_o = 1'b0;
        case (state_q)
            FC_IDLE: begin
                flush_o = ev;
                if (ev) begin
                    capture = 1'b1;
                    state_d = (cnt_nxt != '0) ? FC_DRAIN : FC_REDIR;
                end
            end
            FC_DRAIN: begin
                fetch_hold_o   = 1'b1;
                inst_discard_o = inst_data_ok_i;
                if (cnt_nxt == '0) begin
                    state_d = FC_REDIR;
                end
            end
            FC_REDIR: begin
                fetch_hold_o     = 1'b1;
                redirect_valid_o = 1'b1;
                inst_discard_o   = inst_data_ok_i;
                if (redirect_ready_i) begin
                    state_d = FC_IDLE;
                end
            end
            default: state_d = FC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= FC_IDLE;
            target_q <= EX_VECTOR;
        end else begin
            state_q <= state_d;
            if (capture) begin
                target_q <= ws_ex_i ? EX_VECTOR : cp0_epc_i;
            end
        end
    end

    assign redirect_pc_o = target_q;

    // Nothing may still be in flight once the redirect is being offered.
    stray_data_ok: assert property (@(posedge clk) disable iff (!resetn)
        !(state_q == FC_REDIR && inst_data_ok_i));

endmodule

// File: tb/tb_ex_flush_ctrl.sv
// Directed vector table, reset corner case and random run against a reference model.
module tb_ex_flush_ctrl;
    import ex_flush_ctrl_pkg::*;

    localparam logic [31:0] V = 32'hbfc00380;
    localparam logic [31:0] E = 32'h80001234;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_ex, ws_eret, req, aok, dok, rdy;
    logic [31:0] epc;
    logic        flush, hold, disc, rv;
    logic [31:0] pc;
    logic [1:0]  cnt;

    always #5 clk = ~clk;

    ex_flush_ctrl #(.EX_VECTOR(V), .CNT_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .ws_ex_i(ws_ex), .ws_eret_i(ws_eret), .cp0_epc_i(epc),
        .inst_req_i(req), .inst_addr_ok_i(aok), .inst_data_ok_i(dok),
        .redirect_ready_i(rdy),
        .flush_o(flush), .fetch_hold_o(hold), .inst_discard_o(disc),
        .redirect_valid_o(rv), .redirect_pc_o(pc), .outstanding_o(cnt)
    );

    cnt_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(cnt == 2'd3 && req && aok && !dok));
    cnt_no_underflow: assert property (@(posedge clk) disable iff (!resetn)
        !(cnt == 2'd0 && dok && !(req && aok)));

    typedef struct {
        logic        ex, eret;
        logic [31:0] epc;
        logic        req, aok, dok, rdy;
        logic        flush, hold, disc, rv;
        logic [31:0] pc;
        logic [1:0]  cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: flags for "draining" and "offering redirect",
    // plain integer count of requests in flight.
    bit          m_drain, m_redir;
    int          m_inflight;
    logic [31:0] m_tgt;

    function automatic vec_t mk(logic ex, logic eret, logic [31:0] e,
                                logic rq, logic ao, logic dk, logic ry,
                                logic f, logic h, logic d, logic v,
                                logic [31:0] p, logic [1:0] c);
        vec_t t;
        t.ex = ex; t.eret = eret; t.epc = e;
        t.req = rq; t.aok = ao; t.dok = dk; t.rdy = ry;
        t.flush = f; t.hold = h; t.disc = d; t.rv = v;
        t.pc = p; t.cnt = c;
        return t;
    endfunction

    task automatic drive(logic ex, logic eret, logic [31:0] e,
                         logic rq, logic ao, logic dk, logic ry);
        ws_ex = ex; ws_eret = eret; epc = e;
        req = rq; aok = ao; dok = dk; rdy = ry;
    endtask

    task automatic check(string name, logic f, logic h, logic d, logic v,
                         logic [31:0] p, logic [1:0] c);
        n_vec++;
        if (flush !== f || hold !== h || disc !== d || rv !== v ||
            pc !== p || cnt !== c) begin
            n_bad++;
            $display("FAIL %s: got flush=%b hold=%b disc=%b rv=%b pc=%h cnt=%0d, want flush=%b hold=%b disc=%b rv=%b pc=%h cnt=%0d",
                     name, flush, hold, disc, rv, pc, cnt, f, h, d, v, p, c);
        end
    endtask

    task automatic model_reset();
        m_drain = 0; m_redir = 0; m_inflight = 0; m_tgt = V;
    endtask

    task automatic model_check(string name);
        bit idle;
        idle = !m_drain && !m_redir;
        check(name, idle && (ws_ex || ws_eret), m_drain || m_redir,
              (m_drain || m_redir) && dok, m_redir, m_tgt,
              2'(m_inflight));
    endtask

    task automatic model_step();
        int nc;
        nc = m_inflight + int'(req && aok) - int'(dok);
        if (!m_drain && !m_redir && (ws_ex || ws_eret)) begin
            m_tgt = ws_ex ? V : epc;
            if (nc > 0) m_drain = 1;
            else        m_redir = 1;
        end else if (m_drain && nc == 0) begin
            m_drain = 0;
            m_redir = 1;
        end else if (m_redir && rdy) begin
            m_redir = 0;
        end
        m_inflight = nc;
    endtask

    task automatic run_model(string name);
        #1;
        model_check(name);
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();

        // ex with empty pipe; ev ignored while redirecting; ready held off
        tbl.push_back(mk(1,0,0,         0,0,0,0, 1,0,0,0,V,0));
        tbl.push_back(mk(0,0,0,         0,0,0,0, 0,1,0,1,V,0));
        tbl.push_back(mk(1,0,0,         0,0,0,0, 0,1,0,1,V,0));
        tbl.push_back(mk(0,0,0,         0,0,0,0, 0,1,0,1,V,0));
        tbl.push_back(mk(0,0,0,         0,0,0,1, 0,1,0,1,V,0));
        tbl.push_back(mk(0,0,0,         0,0,0,0, 0,0,0,0,V,0));
        // two in flight, ERET drains both
        tbl.push_back(mk(0,0,0,         1,1,0,0, 0,0,0,0,V,0));
        tbl.push_back(mk(0,0,0,         1,1,0,0, 0,0,0,0,V,1));
        tbl.push_back(mk(0,1,E,         0,0,0,0, 1,0,0,0,V,2));
        tbl.push_back(mk(0,0,0,         0,0,1,0, 0,1,1,0,E,2));
        tbl.push_back(mk(0,0,0,         0,0,0,0, 0,1,0,0,E,1));
        tbl.push_back(mk(0,0,0,         0,0,1,0, 0,1,1,0,E,1));
        tbl.push_back(mk(0,0,0,         0,0,0,1, 0,1,0,1,E,0));
        // one in flight, event and data_ok together
        tbl.push_back(mk(0,0,0,         1,1,0,0, 0,0,0,0,E,0));
        tbl.push_back(mk(1,0,0,         0,0,1,0, 1,0,0,0,E,1));
        tbl.push_back(mk(0,0,0,         0,0,0,1, 0,1,0,1,V,0));
        // event together with addr_ok
        tbl.push_back(mk(1,0,0,         1,1,0,0, 1,0,0,0,V,0));
        tbl.push_back(mk(0,0,0,         0,0,1,0, 0,1,1,0,V,1));
        tbl.push_back(mk(0,0,0,         0,0,0,1, 0,1,0,1,V,0));
        // ex beats eret
        tbl.push_back(mk(0,1,32'h1000,  0,0,0,0, 1,0,0,0,V,0));
        tbl.push_back(mk(0,0,0,         0,0,0,1, 0,1,0,1,32'h1000,0));
        tbl.push_back(mk(1,1,32'h1000,  0,0,0,0, 1,0,0,0,32'h1000,0));
        tbl.push_back(mk(0,0,0,         0,0,0,1, 0,1,0,1,V,0));

        #12;
        check("reset_state", 0, 0, 0, 0, V, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            drive(tbl[i].ex, tbl[i].eret, tbl[i].epc,
                  tbl[i].req, tbl[i].aok, tbl[i].dok, tbl[i].rdy);
            #1;
            check($sformatf("tbl%0d", i), tbl[i].flush, tbl[i].hold,
                  tbl[i].disc, tbl[i].rv, tbl[i].pc, tbl[i].cnt);
            @(posedge clk);
            model_step();
            #1;
        end

        // reset in the middle of a drain with two outstanding
        drive(0, 0, 0, 1, 1, 0, 0); run_model("pre_rst_a");
        drive(0, 0, 0, 1, 1, 0, 0); run_model("pre_rst_b");
        drive(0, 1, 32'h2000, 0, 0, 0, 0); run_model("pre_rst_ev");
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        model_check("drain_before_rst");
        resetn = 1'b0;
        #1;
        check("async_reset", 0, 0, 0, 0, V, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        drive(0, 1, 32'h3000, 0, 0, 0, 0); run_model("post_rst_ev");
        drive(0, 0, 0, 0, 0, 0, 1);        run_model("post_rst_redir");
        drive(0, 0, 0, 0, 0, 0, 0);        run_model("post_rst_idle");

        // random traffic; never over/underflow and no stray data_ok
        for (int i = 0; i < 600; i++) begin
            logic d, a, r;
            d = (m_inflight > 0 && !m_redir) ? 1'($urandom_range(0, 1)) : 1'b0;
            r = 1'($urandom_range(0, 1));
            a = (m_inflight + 1 - int'(d) <= 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  $urandom, r, a, d, $urandom_range(0, 2) == 0);
            run_model($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
